fmap_reader: RTL

Read-side counterpart of the convolution accumulator stage. After the accumulator has written a full output feature map into the shared result buffer at address `i*W+j`, this block walks that buffer in raster order. It issues synchronous reads and streams each signed pixel, tagged with its row and column, over a valid/ready interface to the next stage (pooling or host readout). A 2-entry skid FIFO absorbs memory read latency under backpressure.

---
 rtl/cnn_pkg.sv | 25 ++
 rtl/skid_fifo2.sv | 45 ++++
 rtl/fmap_reader.sv | 134 +++++++++++++
 3 files changed

// File: rtl/cnn_pkg.sv
// Shared CNN datapath types and feature-map geometry defaults.
package cnn_pkg;

    localparam int unsigned FMAP_W      = 28;
    localparam int unsigned FMAP_H      = 28;
    localparam int unsigned FMAP_ADDR_W = 10;
    localparam int unsigned FMAP_DATA_W = 8;
    localparam int unsigned COORD_W     = 5;

    typedef logic signed [FMAP_DATA_W-1:0] pixel_t;

    // Row/column tag that travels with each pixel through the read pipeline.
    typedef struct packed {
        logic [COORD_W-1:0] i;
        logic [COORD_W-1:0] j;
        logic               last;
    } coord_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } rd_state_t;

endpackage

// File: rtl/skid_fifo2.sv
// Two-entry FIFO with a combinational head; push and pop may coincide at any fill level.
module skid_fifo2 #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [1:0]       count,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] slot0;
    logic [WIDTH-1:0] slot1;
    logic             wr_ptr;
    logic             rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (count != 2'd0);
    // When full, a push is only taken if the head leaves in the same cycle.
    assign do_push = push && ((count != 2'd2) || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot0  <= '0;
            slot1  <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                if (wr_ptr) slot1 <= din;
                else        slot0 <= din;
                wr_ptr <= ~wr_ptr;
            end
            if (do_pop) rd_ptr <= ~rd_ptr;
            count <= count + 2'(do_push) - 2'(do_pop);
        end
    end

    assign head = rd_ptr ? slot1 : slot0;

endmodule

// File: rtl/fmap_reader.sv
// Raster-order reader of a finished feature map, streamed with (i, j, last) tags.
// Build option: FMAP_READER_RELU_EN clamps negative pixels to zero before buffering.
module fmap_reader
    import cnn_pkg::*;
#(
    parameter int unsigned W      = FMAP_W,
    parameter int unsigned H      = FMAP_H,
    parameter int unsigned ADDR_W = FMAP_ADDR_W,
    parameter int unsigned DATA_W = FMAP_DATA_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     mem_rd_en,
    output logic [ADDR_W-1:0]        mem_addr,
    input  logic signed [DATA_W-1:0] mem_rdata,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_data,
    output logic [COORD_W-1:0]       out_i,
    output logic [COORD_W-1:0]       out_j,
    output logic                     out_last
);

    localparam int unsigned TAG_W   = $bits(coord_t);
    localparam int unsigned ENTRY_W = DATA_W + TAG_W;

    rd_state_t                 state;
    rd_state_t                 state_next;
    logic [COORD_W-1:0]        ri;
    logic [COORD_W-1:0]        rj;
    logic                      rd_last_c;
    logic                      inflight;
    coord_t                    inflight_tag;
    logic [1:0]                fifo_count;
    logic [ENTRY_W-1:0]        fifo_din;
    logic [ENTRY_W-1:0]        fifo_head;
    logic                      pop;
    logic signed [DATA_W-1:0]  push_data;
    coord_t                    head_tag;
    logic [2:0]                credit;

    assign rd_last_c = (ri == COORD_W'(H - 1)) && (rj == COORD_W'(W - 1));
    assign pop       = out_valid && out_ready;
    // Buffered plus in-flight entries after this cycle's pop; a read is allowed below 2.
    assign credit    = 3'(fifo_count) + 3'(inflight) - 3'(pop);
    assign mem_addr  = ADDR_W'(ri) * ADDR_W'(W) + ADDR_W'(rj);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (start)                  state_next = ST_RUN;
            ST_RUN:   if (mem_rd_en && rd_last_c) state_next = ST_DRAIN;
            ST_DRAIN: if (pop && out_last)        state_next = ST_IDLE;
            default:                              state_next = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        mem_rd_en = 1'b0;
        busy      = 1'b0;
        if (state == ST_RUN)  mem_rd_en = (credit < 3'd2);
        if (state != ST_IDLE) busy      = 1'b1;
    end

    // Raster read counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ri <= '0;
            rj <= '0;
        end else if ((state == ST_IDLE) && start) begin
            ri <= '0;
            rj <= '0;
        end else if (mem_rd_en) begin
            if (rj == COORD_W'(W - 1)) begin
                rj <= '0;
                ri <= ri + COORD_W'(1);
            end else begin
                rj <= rj + COORD_W'(1);
            end
        end
    end

    // Read-latency tracking and completion pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight     <= 1'b0;
            inflight_tag <= '0;
            done         <= 1'b0;
        end else begin
            inflight <= mem_rd_en;
            if (mem_rd_en) inflight_tag <= '{i: ri, j: rj, last: rd_last_c};
            done <= (state == ST_DRAIN) && pop && out_last;
        end
    end

`ifdef FMAP_READER_RELU_EN
    assign push_data = mem_rdata[DATA_W-1] ? '0 : mem_rdata;
`else
    assign push_data = mem_rdata;
`endif

    assign fifo_din = {push_data, inflight_tag};

    skid_fifo2 #(
        .WIDTH(ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (inflight),
        .pop   (pop),
        .din   (fifo_din),
        .count (fifo_count),
        .head  (fifo_head)
    );

    assign head_tag  = fifo_head[TAG_W-1:0];
    assign out_valid = (fifo_count != 2'd0);
    assign out_data  = fifo_head[ENTRY_W-1 -: DATA_W];
    assign out_i     = head_tag.i;
    assign out_j     = head_tag.j;
    assign out_last  = out_valid && head_tag.last;

endmodule
